// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART shared types: FSM states, baud divider, parity selects.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Same truncating division as the helm_uart baud generator so tx and rx bit periods match.
  function automatic int baud_clk_cnt(input int ref_clk_freq, input int baud_rate);
    return ref_clk_freq / baud_rate;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic odd_sel);
    return (^data) ^ odd_sel;
  endfunction

endpackage

// File: rtl/uart_tx_ser_if.sv
// rtl/uart_tx_ser_if.sv - host byte handshake into the UART transmitter.
interface uart_tx_ser_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO; a push into a full FIFO is dropped even when popping.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_ser.sv
// rtl/uart_tx_ser.sv - buffered UART transmitter, LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int REF_CLK_FREQ   = 50000000,
  parameter int UART_BAUD_RATE = 115200,
  parameter int CLK_CNT_BIT    = 16,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          tx_en,
  uart_tx_ser_if.slave                  host,
  output logic                          txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BAUD_CLK_CNT = baud_clk_cnt(REF_CLK_FREQ, UART_BAUD_RATE);
  localparam logic [CLK_CNT_BIT-1:0] BIT_RELOAD = CLK_CNT_BIT'(BAUD_CLK_CNT - 1);
  localparam logic PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e             state;
  logic [CLK_CNT_BIT-1:0]  bit_cnt;
  logic [2:0]              bit_idx;
  logic                    stop_idx;
  logic [7:0]              data_q;
  logic [7:0]              fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    bit_end;
  logic                    last_stop;
  logic                    pop;

  assign bit_end       = (bit_cnt == '0);
  assign last_stop     = (STOP_BITS < 2) || stop_idx;
  assign pop           = tx_en && !fifo_empty &&
                         ((state == ST_IDLE) || ((state == ST_STOP) && bit_end && last_stop));
  assign host.tx_ready = !fifo_full;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (host.tx_valid),
    .pop   (pop),
    .wdata (host.tx_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_q   <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      // Raised one cycle early so the pulse covers the last cycle of the final stop bit.
      tx_done <= (state == ST_STOP) && last_stop && (bit_cnt == CLK_CNT_BIT'(1));
      if (state != ST_IDLE) bit_cnt <= bit_end ? BIT_RELOAD : bit_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            data_q  <= fifo_rdata;
            bit_cnt <= BIT_RELOAD;
            txd     <= 1'b0;
            tx_busy <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: if (bit_end) begin
          txd     <= data_q[0];
          bit_idx <= 3'd0;
          state   <= ST_DATA;
        end
        ST_DATA: if (bit_end) begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              txd   <= parity_bit(data_q, PAR_SEL);
              state <= ST_PARITY;
            end else begin
              txd      <= 1'b1;
              stop_idx <= 1'b0;
              state    <= ST_STOP;
            end
          end else begin
            txd <= data_q[bit_idx + 3'd1];
          end
        end
        ST_PARITY: if (bit_end) begin
          txd      <= 1'b1;
          stop_idx <= 1'b0;
          state    <= ST_STOP;
        end
        ST_STOP: if (bit_end) begin
          if (!last_stop) begin
            stop_idx <= 1'b1;
          end else if (pop) begin
            data_q <= fifo_rdata;
            txd    <= 1'b0;
            state  <= ST_START;
          end else begin
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          txd     <= 1'b1;
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ser.sv
// tb/tb_uart_tx_ser.sv - directed bench: 8N1, 8E1 and 8O2 instances at 16 clocks per bit.
module tb_uart_tx_ser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_b_v    [3];
  logic       tx_en_v    [3];
  logic       tx_valid_v [3];
  logic [7:0] tx_data_v  [3];
  logic       txd_w      [3];
  logic       busy_w     [3];
  logic       done_w     [3];
  logic       ready_w    [3];
  logic [2:0] level_w    [3];

  uart_tx_ser_if bus0 ();
  uart_tx_ser_if bus1 ();
  uart_tx_ser_if bus2 ();
  assign bus0.tx_valid = tx_valid_v[0];
  assign bus0.tx_data  = tx_data_v[0];
  assign ready_w[0]    = bus0.tx_ready;
  assign bus1.tx_valid = tx_valid_v[1];
  assign bus1.tx_data  = tx_data_v[1];
  assign ready_w[1]    = bus1.tx_ready;
  assign bus2.tx_valid = tx_valid_v[2];
  assign bus2.tx_data  = tx_data_v[2];
  assign ready_w[2]    = bus2.tx_ready;

  uart_tx_ser #(.REF_CLK_FREQ(16), .UART_BAUD_RATE(1), .CLK_CNT_BIT(16), .PARITY_EN(0),
                .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_b(rst_b_v[0]), .tx_en(tx_en_v[0]), .host(bus0), .txd(txd_w[0]),
    .tx_busy(busy_w[0]), .tx_done(done_w[0]), .fifo_level(level_w[0]));

  uart_tx_ser #(.REF_CLK_FREQ(16), .UART_BAUD_RATE(1), .CLK_CNT_BIT(16), .PARITY_EN(1),
                .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst_b(rst_b_v[1]), .tx_en(tx_en_v[1]), .host(bus1), .txd(txd_w[1]),
    .tx_busy(busy_w[1]), .tx_done(done_w[1]), .fifo_level(level_w[1]));

  uart_tx_ser #(.REF_CLK_FREQ(16), .UART_BAUD_RATE(1), .CLK_CNT_BIT(16), .PARITY_EN(1),
                .PARITY_ODD(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8o2 (
    .clk(clk), .rst_b(rst_b_v[2]), .tx_en(tx_en_v[2]), .host(bus2), .txd(txd_w[2]),
    .tx_busy(busy_w[2]), .tx_done(done_w[2]), .fifo_level(level_w[2]));

  // Line receiver: frames recorded as bits in time order, bit 0 = start bit.
  logic [11:0] rx_q   [3][$];
  int          fall_q [3][$];
  int          done_q [3][$];

  initial begin
    logic        rx_act [3];
    int          rx_t   [3];
    logic [11:0] fr     [3];
    int          nb;
    for (int g = 0; g < 3; g++) rx_act[g] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        nb = (g == 0) ? 10 : (g == 1) ? 11 : 12;
        if (done_w[g] === 1'b1) done_q[g].push_back(cyc);
        if (rx_act[g]) begin
          rx_t[g] = rx_t[g] + 1;
          if (rx_t[g] % 16 == 8) begin
            fr[g][rx_t[g] / 16] = txd_w[g];
            if (rx_t[g] / 16 == nb - 1) begin
              rx_q[g].push_back(fr[g]);
              rx_act[g] = 1'b0;
            end
          end
        end else if (rst_b_v[g] === 1'b1 && txd_w[g] === 1'b0) begin
          rx_act[g] = 1'b1;
          rx_t[g]   = 0;
          fr[g]     = '0;
          fall_q[g].push_back(cyc);
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] d, output logic acc, output int e);
    @(negedge clk);
    tx_valid_v[g] = 1'b1;
    tx_data_v[g]  = d;
    acc = ready_w[g];
    @(negedge clk);
    e = cyc;
    tx_valid_v[g] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int g, input int n, input int budget);
    int t = 0;
    while (done_q[g].size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(done_q[g].size() >= n), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        acc;
    int          e, t, db, fb, rb, nd;
    logic [11:0] exp_seq [3];
    logic [11:0] exp_q   [4];

    for (int g = 0; g < 3; g++) begin
      rst_b_v[g] = 1'b0; tx_en_v[g] = 1'b1; tx_valid_v[g] = 1'b0; tx_data_v[g] = 8'h00;
    end
    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++) rst_b_v[g] = 1'b1;
    @(negedge clk);
    chk("rst_txd",   txd_w[0],   1);
    chk("rst_busy",  busy_w[0],  0);
    chk("rst_done",  done_w[0],  0);
    chk("rst_level", level_w[0], 0);
    chk("rst_ready", ready_w[0], 1);

    // 8N1 single byte
    push(0, 8'hA5, acc, e);
    chk("a5_accept",   acc,      1);
    chk("a5_nobypass", txd_w[0], 1);
    wait_done("a5_wait", 0, 1, 300);
    repeat (20) @(negedge clk);
    chk("a5_latency", fall_q[0][0] - e, 1);
    chk("a5_frame",   rx_q[0][0], 12'h34A);
    chk("a5_length",  done_q[0][0] - fall_q[0][0], 159);
    chk("a5_ndone",   done_q[0].size(), 1);
    chk("a5_idle",    busy_w[0], 0);

    // Even parity, 1 stop
    push(1, 8'hA5, acc, e);
    wait_done("e1_wait", 1, 1, 300);
    repeat (20) @(negedge clk);
    chk("e1_frame",  rx_q[1][0], 12'h54A);
    chk("e1_length", done_q[1][0] - fall_q[1][0], 175);

    // Odd parity, 2 stops
    push(2, 8'hA5, acc, e);
    wait_done("o2_wait", 2, 1, 300);
    repeat (20) @(negedge clk);
    chk("o2_frame",  rx_q[2][0], 12'hF4A);
    chk("o2_length", done_q[2][0] - fall_q[2][0], 191);

    // Back-to-back frames
    db = done_q[0].size(); fb = fall_q[0].size(); rb = rx_q[0].size();
    exp_seq = '{12'h202, 12'h204, 12'h206};
    for (int k = 0; k < 3; k++) push(0, 8'(k + 1), acc, e);
    wait_done("b2b_wait", 0, db + 3, 700);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("b2b_frame%0d", k), rx_q[0][rb + k], exp_seq[k]);
    chk("b2b_space0", done_q[0][db + 1] - done_q[0][db], 160);
    chk("b2b_space1", done_q[0][db + 2] - done_q[0][db + 1], 160);
    chk("b2b_gap0",   fall_q[0][fb + 1] - done_q[0][db], 1);
    chk("b2b_gap1",   fall_q[0][fb + 2] - done_q[0][db + 1], 1);
    chk("b2b_total",  done_q[0][db + 2] - fall_q[0][fb], 479);

    // Fill while disabled, then drain
    tx_en_v[0] = 1'b0;
    db = done_q[0].size(); rb = rx_q[0].size();
    for (int k = 0; k < 5; k++) begin
      push(0, 8'h10 + 8'(k), acc, e);
      chk($sformatf("fill_accept%0d", k), acc, (k < 4) ? 1 : 0);
    end
    chk("full_ready", ready_w[0], 0);
    chk("full_level", level_w[0], 4);
    tx_en_v[0] = 1'b1;
    @(negedge clk);
    chk("drain_level3", level_w[0], 3);
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (done_w[0] !== 1'b1 && t < 400) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      chk($sformatf("drain_level%0d", 2 - k), level_w[0], 2 - k);
    end
    wait_done("drain_wait", 0, db + 4, 400);
    repeat (30) @(negedge clk);
    chk("drain_ndone", done_q[0].size(), db + 4);
    exp_q = '{12'h220, 12'h222, 12'h224, 12'h226};
    for (int k = 0; k < 4; k++) chk($sformatf("drain_frame%0d", k), rx_q[0][rb + k], exp_q[k]);

    // tx_en dropped mid-frame
    db = done_q[0].size(); rb = rx_q[0].size();
    push(0, 8'h21, acc, e);
    push(0, 8'h22, acc, e);
    push(0, 8'h23, acc, e);
    repeat (60) @(negedge clk);
    tx_en_v[0] = 1'b0;
    wait_done("hold_wait", 0, db + 1, 300);
    repeat (40) @(negedge clk);
    chk("hold_busy",  busy_w[0],  0);
    chk("hold_level", level_w[0], 2);
    chk("hold_txd",   txd_w[0],   1);
    chk("hold_ndone", done_q[0].size(), db + 1);
    chk("hold_frame", rx_q[0][rb], 12'h242);

    // Reset during DATA
    tx_en_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("pre_rst_busy",  busy_w[0],  1);
    chk("pre_rst_level", level_w[0], 1);
    nd = done_q[0].size();
    rst_b_v[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd",   txd_w[0],   1);
    chk("mid_rst_level", level_w[0], 0);
    chk("mid_rst_busy",  busy_w[0],  0);
    chk("mid_rst_done",  done_w[0],  0);
    repeat (3) @(negedge clk);
    rst_b_v[0] = 1'b1;
    repeat (250) @(negedge clk);
    chk("post_rst_ndone", done_q[0].size(), nd);
    chk("post_rst_txd",   txd_w[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
